// File: rtl/logic_sweep_ctrl_if.sv
// Host/network-side bundle of the logic sweep sequencer: sweep control, gate-network drive and results.
interface logic_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] signature;
  logic [7:0] unstable;
  logic       match;

  modport master (
    output start, abort, expected, dut_out,
    input  in1, in2, in3, busy, done, signature, unstable, match
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output in1, in2, in3, busy, done, signature, unstable, match
  );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// Sweeps all 8 input combinations of a 3-input gate network, one every SETTLE_CYCLES+HOLD_CYCLES cycles,
// and records its truth table and hold-window instability. LOGIC_SWEEP_GRAY_EN selects Gray-code sweep order.
module logic_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  logic_sweep_ctrl_if.slave bus
);

  localparam int CMAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    step;
  logic [2:0]    drive;
  logic          ref_smp;
  logic [7:0]    sig_r, uns_r, sig_upd, uns_upd;
  logic          match_r;
  logic          busy_c, done_c;
  logic [2:0]    idx;

  // Maps sweep step to the combination applied; results stay indexed by combination.
  function automatic logic [2:0] order(input logic [2:0] s);
`ifdef LOGIC_SWEEP_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  assign idx = order(step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    sig_upd   = sig_r;
    uns_upd   = uns_r;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) state_nxt = SETTLE;
      end
      SETTLE: begin
        busy_c = 1'b1;
        if (bus.abort)         state_nxt = IDLE;
        else if (cnt == S_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        busy_c = 1'b1;
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          // First hold sample is the reference; the last one is the recorded value.
          if (cnt != '0 && bus.dut_out != ref_smp) uns_upd[idx] = 1'b1;
          if (cnt == H_LAST) begin
            sig_upd[idx] = bus.dut_out;
            state_nxt    = (step == 3'd7) ? DONE : SETTLE;
          end
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      step    <= 3'd0;
      drive   <= 3'd0;
      ref_smp <= 1'b0;
      sig_r   <= 8'h00;
      uns_r   <= 8'h00;
      match_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            step    <= 3'd0;
            drive   <= order(3'd0);
            sig_r   <= 8'h00;
            uns_r   <= 8'h00;
            match_r <= 1'b0;
            cnt     <= '0;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            drive   <= 3'd0;
            cnt     <= '0;
            match_r <= 1'b0;
          end else if (cnt == S_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.abort) begin
            drive   <= 3'd0;
            cnt     <= '0;
            match_r <= 1'b0;
          end else begin
            sig_r <= sig_upd;
            uns_r <= uns_upd;
            if (cnt == '0) ref_smp <= bus.dut_out;
            if (cnt == H_LAST) begin
              cnt <= '0;
              if (step == 3'd7) begin
                drive   <= 3'd0;
                match_r <= (sig_upd == bus.expected) && (uns_upd == 8'h00);
              end else begin
                step  <= step + 3'd1;
                drive <= order(step + 3'd1);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in1       = drive[2];
  assign bus.in2       = drive[1];
  assign bus.in3       = drive[0];
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.signature = sig_r;
  assign bus.unstable  = uns_r;
  assign bus.match     = match_r;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Scoreboarded bench for logic_sweep_ctrl driving a behavioural 0x7E gate network.
module tb_logic_sweep_ctrl;
  localparam int S = 4;
  localparam int H = 2;
  localparam int SWEEP = 8 * (S + H);

  typedef struct {
    logic [7:0] sig;
    logic [7:0] uns;
    logic       match;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_sweep_ctrl_if bus();

  logic_sweep_ctrl #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int st_cyc = 0;
  int age   = 0;
  exp_t sb[$];
  logic [2:0] seq[$];
  logic [2:0] exp_seq[8];
  logic [2:0] last_vec = 3'd0;
  logic       last_busy = 1'b0;
  logic       stuck = 1'b0;
  logic       glitch_en = 1'b0;
  logic [2:0] vec_now;
  logic       net;

  // Behavioural network: out=0 only when all three inputs agree (0x7E).
  assign vec_now = {bus.in1, bus.in2, bus.in3};
  assign net     = ~((bus.in1 & bus.in2 & bus.in3) | (~bus.in1 & ~bus.in2 & ~bus.in3));
  assign bus.dut_out = stuck ? 1'b1 : (net ^ (glitch_en && vec_now == 3'd5 && age == S));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Tracks cycles since the current combination was applied and logs the applied sequence.
  always @(posedge clk) begin
    #1;
    if (vec_now != last_vec || (bus.busy && !last_busy)) begin
      age = 0;
      if (bus.busy) seq.push_back(vec_now);
    end else begin
      age = age + 1;
    end
    last_vec  = vec_now;
    last_busy = bus.busy;
  end

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("signature", {24'd0, bus.signature}, {24'd0, e.sig});
        chk("unstable", {24'd0, bus.unstable}, {24'd0, e.uns});
        chk("match", {31'd0, bus.match}, {31'd0, e.match});
        chk("done_latency", cyc - st_cyc, SWEEP);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
    tick(2);
  endtask

  task automatic check_idle_zero(input string tag, input logic [7:0] sig);
    chk({tag, "_inputs"}, {29'd0, vec_now}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_signature"}, {24'd0, bus.signature}, {24'd0, sig});
    chk({tag, "_unstable"}, {24'd0, bus.unstable}, 32'd0);
    chk({tag, "_match"}, {31'd0, bus.match}, 32'd0);
  endtask

  initial begin
    logic [7:0] abort_sig;
`ifdef LOGIC_SWEEP_GRAY_EN
    exp_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    abort_sig = 8'h0A;
`else
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    abort_sig = 8'h06;
`endif
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.expected = 8'h7E;

    tick(2);
    check_idle_zero("reset", 8'h00);
    rst = 1'b0;
    tick(2);

    // Clean 0x7E sweep with a stray start mid-sweep that must not restart it.
    seq.delete();
    sb.push_back('{sig: 8'h7E, uns: 8'h00, match: 1'b1});
    do_start();
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    tick(20);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_done();
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
    chk("seq_len", seq.size(), 32'd8);
    for (int i = 0; i < 8 && i < seq.size(); i++)
      chk($sformatf("seq_%0d", i), {29'd0, seq[i]}, {29'd0, exp_seq[i]});

    // Output stuck at 1.
    stuck = 1'b1;
    sb.push_back('{sig: 8'hFF, uns: 8'h00, match: 1'b0});
    do_start();
    wait_done();
    stuck = 1'b0;

    // Glitch in the hold window of combination 5 only.
    glitch_en = 1'b1;
    sb.push_back('{sig: 8'h7E, uns: 8'h20, match: 1'b0});
    do_start();
    wait_done();
    glitch_en = 1'b0;

    // Abort (with start) during SETTLE of step 3.
    do_start();
    tick(19);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_idle_zero("abort", abort_sig);
    tick(60);
    sb.push_back('{sig: 8'h7E, uns: 8'h00, match: 1'b1});
    do_start();
    wait_done();

    // Asynchronous reset in the middle of HOLD.
    do_start();
    tick(10);
    rst = 1'b1;
    #1;
    check_idle_zero("rst_mid", 8'h00);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
